// File: rtl/if_fetch_unit.sv
// Purpose: instruction-fetch front end; owns the PC, issues single-outstanding imem reads,
//          buffers one fetched instruction (+PC+2) for the IF/ID register, squashes wrong-path data.
// Latency: issue -> response (1..N cycles) -> buffered; at best one instruction every 2 cycles.
// Backpressure: stall/Stall_DM hold the buffered instruction and block the next request;
//               an empty buffer presents a NOP bubble with fetch_busy=1.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   stall, Stall_DM            IF/ID hold requests; accept = neither asserted
//   branch_taken/target        one-cycle redirect pulse and new PC
//   imem_req/addr              one-cycle request pulse and fetch address
//   imem_rdata/valid           returned instruction and its valid strobe
//   instruction, PC_inc        IF/ID write-side data (NOP when empty)
//   fetch_busy                 output buffer empty
//
// Optional: define IF_FETCH_HALT_DETECT_EN to stop fetching after an instruction whose
// opcode [15:12] equals HALT_OP; only reset or a redirect resumes fetching.

module if_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INS  = 16'h0800,
    parameter logic [3:0]  HALT_OP  = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        Stall_DM,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    output logic [15:0] instruction,
    output logic [15:0] PC_inc,
    output logic        fetch_busy
);

`ifdef IF_FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    // Halt opcode is an ordinary instruction; S_HALT is never entered.
    localparam bit HALT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [15:0] pc, pc_n;
    logic [15:0] buf_ins, buf_ins_n;
    logic [15:0] buf_pc_inc, buf_pc_inc_n;
    logic        buf_v, buf_v_n;
    logic        squash, squash_n;
    logic        accept;
    logic        halt_hit;
    logic [15:0] pc_plus2;

    assign accept   = ~stall & ~Stall_DM;
    assign pc_plus2 = pc + 16'd2;   // wraps modulo 2^16
    assign halt_hit = HALT_EN && (imem_rdata[15:12] == HALT_OP);

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        buf_ins_n    = buf_ins;
        buf_pc_inc_n = buf_pc_inc;
        buf_v_n      = buf_v;
        squash_n     = squash;
        imem_req     = 1'b0;
        imem_addr    = pc;

        // IF/ID takes the held instruction on every accept cycle.
        if (accept) begin
            buf_v_n = 1'b0;
        end

        case (state)
            S_IDLE: begin
                state_n = S_ISSUE;
            end
            S_ISSUE: begin
                // A held instruction that IF/ID is not taking blocks the next fetch,
                // since the buffer must be free when the response lands.
                if (!(buf_v && !accept)) begin
                    imem_req = 1'b1;
                    state_n  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_valid) begin
                    state_n = S_ISSUE;
                    if (squash) begin
                        squash_n = 1'b0;
                    end else begin
                        buf_ins_n    = imem_rdata;
                        buf_pc_inc_n = pc_plus2;
                        buf_v_n      = 1'b1;
                        pc_n         = pc_plus2;
                        if (halt_hit) begin
                            pc_n    = pc;
                            state_n = S_HALT;
                        end
                    end
                end
            end
            S_HALT: begin
                state_n = S_HALT;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Redirect overrides everything above, including a same-cycle load.
        if (branch_taken) begin
            pc_n         = branch_target;
            buf_v_n      = 1'b0;
            buf_ins_n    = buf_ins;
            buf_pc_inc_n = buf_pc_inc;
            case (state)
                S_WAIT: begin
                    if (imem_valid) begin
                        // Wrong-path response consumed right now; nothing left to drop.
                        squash_n = 1'b0;
                        state_n  = S_ISSUE;
                    end else begin
                        squash_n = 1'b1;
                    end
                end
                S_ISSUE: begin
                    // Request going out this cycle is to the old PC.
                    if (imem_req) begin
                        squash_n = 1'b1;
                    end
                end
                S_HALT: begin
                    state_n = S_ISSUE;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            buf_ins    <= NOP_INS;
            buf_pc_inc <= 16'h0000;
            buf_v      <= 1'b0;
            squash     <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            buf_ins    <= buf_ins_n;
            buf_pc_inc <= buf_pc_inc_n;
            buf_v      <= buf_v_n;
            squash     <= squash_n;
        end
    end

    assign instruction = buf_v ? buf_ins : NOP_INS;
    assign PC_inc      = buf_pc_inc;
    assign fetch_busy  = ~buf_v;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, hand-written redirect/wrap/halt
// sequences, then randomized traffic against a transaction-level fetch model.

module tb_if_fetch_unit;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        Stall_DM;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic [15:0] instruction;
    logic [15:0] PC_inc;
    logic        fetch_busy;

    if_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .Stall_DM     (Stall_DM),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_valid   (imem_valid),
        .instruction  (instruction),
        .PC_inc       (PC_inc),
        .fetch_busy   (fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Waits for the next falling edge, drives one cycle of inputs, settles combinational outputs.
    task automatic cyc(input bit rst, input logic [1:0] st, input bit br, input logic [15:0] tgt,
                       input bit vld, input logic [15:0] rd);
        @(negedge clk);
        rst_n         = ~rst;
        stall         = st[0];
        Stall_DM      = st[1];
        branch_taken  = br;
        branch_target = tgt;
        imem_valid    = vld;
        imem_rdata    = rd;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [15:0] ins, input logic [15:0] inc, input bit busy);
        chk({tag, ".ins"}, instruction, ins);
        chk({tag, ".pc_inc"}, PC_inc, inc);
        chk({tag, ".busy"}, {15'd0, fetch_busy}, {15'd0, busy});
    endtask

    task automatic chk_req(input string tag, input bit req, input logic [15:0] addr);
        chk({tag, ".req"}, {15'd0, imem_req}, {15'd0, req});
        if (req) chk({tag, ".addr"}, imem_addr, addr);
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a ^ 16'h5A3C) & 16'h7FFF;   // opcode never 4'hF
    endfunction

    typedef struct {
        bit          rst;
        logic [1:0]  st;      // {Stall_DM, stall}
        bit          br;
        logic [15:0] tgt;
        bit          vld;
        logic [15:0] rd;
        bit          e_req;
        logic [15:0] e_addr;
        logic [15:0] e_ins;
        logic [15:0] e_inc;
        bit          e_busy;
    } vec_t;

    function automatic vec_t v(input bit rst, input logic [1:0] st, input bit vld, input logic [15:0] rd,
                               input bit e_req, input logic [15:0] e_addr, input logic [15:0] e_ins,
                               input logic [15:0] e_inc, input bit e_busy);
        vec_t r;
        r.rst = rst; r.st = st; r.br = 1'b0; r.tgt = 16'h0000; r.vld = vld; r.rd = rd;
        r.e_req = e_req; r.e_addr = e_addr; r.e_ins = e_ins; r.e_inc = e_inc; r.e_busy = e_busy;
        return r;
    endfunction

    vec_t tbl[$];

    // Random-phase model state
    bit          held, inflight, dead, acc, resp, br_r, vld_r;
    logic [15:0] held_addr, fl_addr, exp_fetch, last_inc, req_exp, tgt_r, rd_r;
    logic [1:0]  st_r;
    int          cnt, delivered;

    initial begin
        rst_n = 1'b0; stall = 1'b0; Stall_DM = 1'b0; branch_taken = 1'b0;
        branch_target = 16'h0000; imem_valid = 1'b0; imem_rdata = 16'h0000;

        // ---- 1-cycle memory, accept=1; then reset mid-wait, stray valid, stall hold ----
        tbl.push_back(v(1, 2'b00, 0, 16'h0000, 0, 16'h0000, NOP,      16'h0000, 1)); // reset
        tbl.push_back(v(0, 2'b00, 0, 16'h0000, 0, 16'h0000, NOP,      16'h0000, 1)); // idle
        tbl.push_back(v(0, 2'b00, 0, 16'h0000, 1, 16'h0000, NOP,      16'h0000, 1)); // issue 0
        tbl.push_back(v(0, 2'b00, 1, 16'h1234, 0, 16'h0000, NOP,      16'h0000, 1)); // resp
        tbl.push_back(v(0, 2'b00, 0, 16'h0000, 1, 16'h0002, 16'h1234, 16'h0002, 0)); // show+issue 2
        tbl.push_back(v(0, 2'b00, 1, 16'h5678, 0, 16'h0000, NOP,      16'h0002, 1)); // bubble
        tbl.push_back(v(0, 2'b00, 0, 16'h0000, 1, 16'h0004, 16'h5678, 16'h0004, 0)); // show+issue 4
        tbl.push_back(v(0, 2'b00, 0, 16'h0000, 0, 16'h0000, NOP,      16'h0004, 1)); // waiting
        tbl.push_back(v(1, 2'b00, 0, 16'h0000, 0, 16'h0000, NOP,      16'h0000, 1)); // reset mid-wait
        tbl.push_back(v(0, 2'b00, 1, 16'hBEEF, 0, 16'h0000, NOP,      16'h0000, 1)); // stray in idle
        tbl.push_back(v(0, 2'b00, 1, 16'hBEEF, 1, 16'h0000, NOP,      16'h0000, 1)); // stray in issue
        tbl.push_back(v(0, 2'b00, 1, 16'h1234, 0, 16'h0000, NOP,      16'h0000, 1));
        tbl.push_back(v(0, 2'b01, 0, 16'h0000, 0, 16'h0000, 16'h1234, 16'h0002, 0)); // stall x4
        tbl.push_back(v(0, 2'b10, 0, 16'h0000, 0, 16'h0000, 16'h1234, 16'h0002, 0));
        tbl.push_back(v(0, 2'b11, 0, 16'h0000, 0, 16'h0000, 16'h1234, 16'h0002, 0));
        tbl.push_back(v(0, 2'b01, 0, 16'h0000, 0, 16'h0000, 16'h1234, 16'h0002, 0));
        tbl.push_back(v(0, 2'b00, 0, 16'h0000, 1, 16'h0002, 16'h1234, 16'h0002, 0)); // first accept
        tbl.push_back(v(0, 2'b00, 1, 16'h5678, 0, 16'h0000, NOP,      16'h0002, 1));
        tbl.push_back(v(0, 2'b01, 0, 16'h0000, 0, 16'h0000, 16'h5678, 16'h0004, 0));

        foreach (tbl[i]) begin
            cyc(tbl[i].rst, tbl[i].st, tbl[i].br, tbl[i].tgt, tbl[i].vld, tbl[i].rd);
            chk_out($sformatf("vec%0d", i), tbl[i].e_ins, tbl[i].e_inc, tbl[i].e_busy);
            chk_req($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr);
        end

        // ---- redirect during a 3-cycle fetch ----
        cyc(1, 2'b00, 0, 16'h0000, 0, 16'h0000);
        cyc(0, 2'b00, 0, 16'h0000, 0, 16'h0000);
        cyc(0, 2'b00, 0, 16'h0000, 0, 16'h0000);
        cyc(0, 2'b00, 0, 16'h0000, 1, 16'h1234);
        cyc(0, 2'b00, 0, 16'h0000, 0, 16'h0000);
        cyc(0, 2'b00, 0, 16'h0000, 1, 16'h5678);
        cyc(0, 2'b00, 0, 16'h0000, 0, 16'h0000);  chk_req("br3.issue4", 1, 16'h0004);
        cyc(0, 2'b00, 0, 16'h0000, 0, 16'h0000);
        cyc(0, 2'b00, 1, 16'h0100, 0, 16'h0000);  chk_out("br3.redirect", NOP, 16'h0004, 1);
        cyc(0, 2'b00, 0, 16'h0000, 1, 16'hDEAD);  chk_out("br3.squashed", NOP, 16'h0004, 1);
                                                  chk_req("br3.squashed", 0, 16'h0000);
        cyc(0, 2'b00, 0, 16'h0000, 0, 16'h0000);  chk_req("br3.target", 1, 16'h0100);
        cyc(0, 2'b00, 0, 16'h0000, 1, 16'hAAAA);
        cyc(0, 2'b00, 0, 16'h0000, 0, 16'h0000);  chk_out("br3.data", 16'hAAAA, 16'h0102, 0);
                                                  chk_req("br3.next", 1, 16'h0102);
        // ---- redirect coinciding with the response ----
        cyc(0, 2'b00, 1, 16'h0200, 1, 16'hBBBB);  chk_out("br4.same", NOP, 16'h0102, 1);
        cyc(0, 2'b00, 0, 16'h0000, 0, 16'h0000);  chk_out("br4.noload", NOP, 16'h0102, 1);
                                                  chk_req("br4.target", 1, 16'h0200);
        cyc(0, 2'b00, 0, 16'h0000, 1, 16'hCCCC);
        // ---- redirect to 0xFFFE while issuing; PC+2 wraps ----
        cyc(0, 2'b00, 1, 16'hFFFE, 0, 16'h0000);  chk_out("br4.data", 16'hCCCC, 16'h0202, 0);
                                                  chk_req("br5.issue_old", 1, 16'h0202);
        cyc(0, 2'b00, 0, 16'h0000, 1, 16'h1111);  chk_out("br5.drop", NOP, 16'h0202, 1);
                                                  chk_req("br5.drop", 0, 16'h0000);
        cyc(0, 2'b00, 0, 16'h0000, 0, 16'h0000);  chk_req("br5.target", 1, 16'hFFFE);
        cyc(0, 2'b00, 0, 16'h0000, 1, 16'h2222);
        cyc(0, 2'b00, 0, 16'h0000, 0, 16'h0000);  chk_out("br5.wrap", 16'h2222, 16'h0000, 0);
                                                  chk_req("br5.wrap", 1, 16'h0000);

        // ---- halt opcode ----
        cyc(1, 2'b00, 0, 16'h0000, 0, 16'h0000);
        cyc(0, 2'b00, 0, 16'h0000, 0, 16'h0000);
        cyc(0, 2'b00, 0, 16'h0000, 0, 16'h0000);  chk_req("halt.issue0", 1, 16'h0000);
        cyc(0, 2'b00, 0, 16'h0000, 1, 16'hF000);
`ifdef IF_FETCH_HALT_DETECT_EN
        cyc(0, 2'b00, 0, 16'h0000, 0, 16'h0000);  chk_out("halt.show", 16'hF000, 16'h0002, 0);
                                                  chk_req("halt.noreq1", 0, 16'h0000);
        cyc(0, 2'b00, 0, 16'h0000, 0, 16'h0000);  chk_out("halt.nop", NOP, 16'h0002, 1);
                                                  chk_req("halt.noreq2", 0, 16'h0000);
        cyc(0, 2'b00, 1, 16'h0040, 0, 16'h0000);  chk_req("halt.noreq3", 0, 16'h0000);
        cyc(0, 2'b00, 0, 16'h0000, 0, 16'h0000);  chk_req("halt.resume", 1, 16'h0040);
`else
        cyc(0, 2'b00, 0, 16'h0000, 0, 16'h0000);  chk_out("haltop.show", 16'hF000, 16'h0002, 0);
                                                  chk_req("haltop.ordinary", 1, 16'h0002);
`endif

        // ---- randomized traffic vs. transaction-level model ----
        cyc(1, 2'b00, 0, 16'h0000, 0, 16'h0000);
        held = 0; inflight = 0; dead = 0; exp_fetch = 16'h0000; last_inc = 16'h0000;
        held_addr = 16'h0000; fl_addr = 16'h0000; cnt = 0; delivered = 0;
        for (int i = 0; i < 3000; i++) begin
            st_r  = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 3)};
            br_r  = ($urandom_range(0, 19) == 0);
            tgt_r = ($urandom_range(0, 7) == 0) ? 16'hFFFE : (16'($urandom) & 16'hFFFE);
            vld_r = 1'b0;
            rd_r  = 16'($urandom);
            if (inflight) begin
                if (cnt == 1) begin vld_r = 1'b1; rd_r = mem_word(fl_addr); end
                else cnt--;
            end else if ($urandom_range(0, 15) == 0) begin
                vld_r = 1'b1;   // stray strobe outside a fetch
            end
            cyc(0, st_r, br_r, tgt_r, vld_r, rd_r);
            acc  = (st_r == 2'b00);
            resp = vld_r && inflight;

            chk("rnd.busy", {15'd0, fetch_busy}, {15'd0, !held});
            chk("rnd.ins", instruction, held ? mem_word(held_addr) : NOP);
            chk("rnd.pc_inc", PC_inc, last_inc);
            req_exp = exp_fetch;
            if (imem_req) begin
                chk("rnd.single_outstanding", {15'd0, inflight}, 16'h0000);
                chk("rnd.req_while_held", {15'd0, held && !acc}, 16'h0000);
                chk("rnd.req_addr", imem_addr, req_exp);
                cnt = $urandom_range(1, 4);
            end

            if (br_r) begin
                exp_fetch = tgt_r;
                held = 0;
                if (resp) begin inflight = 0; dead = 0; end
                else if (inflight) dead = 1;
            end else begin
                if (held && acc) begin held = 0; delivered++; end
                if (resp) begin
                    inflight = 0;
                    if (!dead) begin
                        held = 1; held_addr = fl_addr;
                        last_inc = fl_addr + 16'd2; exp_fetch = fl_addr + 16'd2;
                    end
                    dead = 0;
                end
            end
            if (imem_req) begin inflight = 1; fl_addr = req_exp; dead = br_r; end
        end
        chk("rnd.progress", {15'd0, (delivered >= 200)}, 16'h0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
